ifetch_queue: RTL and testbench

- Decoupling instruction queue between the fetch stage and the decode stage.
- Captures each fetched bundle {instr, pc, pred_v, pred_taken} and presents it to decode under a valid/ready handshake, so decode back-pressure does not stall fetch until the queue fills.
- Flushed by the EXE redirect (flush_v_q_i), at the same time as fetch is redirected.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/ifetch_queue.sv | 114 +++++++++++
 tb/tb_ifetch_queue.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core types and constants used by the instruction fetch queue
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int IFQ_DEPTH = 4;

  // One fetched bundle as it travels from fetch to decode
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            pred_v;
    logic            pred_taken;
  } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - fetch-to-decode decoupling FIFO; IFQ_BYPASS_EN enables empty-queue bypass
module ifetch_queue
  import riscv_pkg::ifq_entry_t;
  import riscv_pkg::IFQ_DEPTH;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int XLEN  = riscv_pkg::XLEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_v_q_i,
  input  logic                       if_valid_i,
  output logic                       if_ready_o,
  input  logic [31:0]                if_instr_i,
  input  logic [XLEN-1:0]            if_pc_i,
  input  logic                       if_pred_v_i,
  input  logic                       if_pred_taken_i,
  output logic                       dec_valid_o,
  input  logic                       dec_ready_i,
  output logic [31:0]                dec_instr_o,
  output logic [XLEN-1:0]            dec_pc_o,
  output logic                       dec_pred_v_o,
  output logic                       dec_pred_taken_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  ifq_entry_t        r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic              w_empty;
  logic              w_full;
  logic              w_byp;
  logic              w_push;
  logic              w_pop;
  ifq_entry_t        w_in;
  ifq_entry_t        w_out;

  // Handshake decode, output muxing and the optional empty-queue bypass
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == CW'(DEPTH));
    w_in    = '{instr: if_instr_i, pc: if_pc_i, pred_v: if_pred_v_i, pred_taken: if_pred_taken_i};
`ifdef IFQ_BYPASS_EN
    w_byp   = w_empty & if_valid_i & ~flush_v_q_i & ~reset;
`else
    w_byp   = 1'b0;
`endif
    // A bypassed bundle that decode takes right away never enters the array
    w_push  = if_valid_i & ~w_full & ~flush_v_q_i & ~(w_byp & dec_ready_i);
    w_pop   = ~w_empty & dec_ready_i & ~flush_v_q_i;
    if (w_byp) begin
      w_out = w_in;
    end else if (w_empty) begin
      w_out = '0;
    end else begin
      w_out = r_mem[r_rd_ptr];
    end
  end

  assign if_ready_o       = ~w_full;
  assign dec_valid_o      = ~w_empty | w_byp;
  assign dec_instr_o      = w_out.instr;
  assign dec_pc_o         = w_out.pc;
  assign dec_pred_v_o     = w_out.pred_v;
  assign dec_pred_taken_o = w_out.pred_taken;
  assign count_o          = r_count;
  assign empty_o          = w_empty;
  assign full_o           = w_full;

  // Pointers and occupancy; flush outranks any push or pop in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_v_q_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage as plain flops, cleared on reset so nothing stale survives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_in;
    end
  end

`ifndef SYNTHESIS
  // Occupancy can never exceed the number of entries
  always @(posedge clk) begin
    assert (r_count <= CW'(DEPTH)) else $error("ifetch_queue: count overflow %0d", r_count);
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed table-driven bench for ifetch_queue
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam bit P = 1'b1;
`else
  localparam bit P = 1'b0;
`endif
  localparam logic [31:0] IMASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_v_q_i, if_valid_i, if_ready_o;
  logic [31:0] if_instr_i, if_pc_i;
  logic        if_pred_v_i, if_pred_taken_i;
  logic        dec_valid_o, dec_ready_i;
  logic [31:0] dec_instr_o, dec_pc_o;
  logic        dec_pred_v_o, dec_pred_taken_o;
  logic [2:0]  count_o;
  logic        empty_o, full_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ifetch_queue dut (
    .clk(clk), .reset(reset), .flush_v_q_i(flush_v_q_i),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_instr_i(if_instr_i),
    .if_pc_i(if_pc_i), .if_pred_v_i(if_pred_v_i), .if_pred_taken_i(if_pred_taken_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i), .dec_instr_o(dec_instr_o),
    .dec_pc_o(dec_pc_o), .dec_pred_v_o(dec_pred_v_o), .dec_pred_taken_o(dec_pred_taken_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
  );

  typedef struct {
    logic        fl, vin, pv, pt, rdy;
    logic [31:0] pc;
    logic        e_ifr, e_dv, e_pv, e_pt;
    logic [31:0] e_pc;
    int          e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fl, vin, input logic [31:0] pc, input logic pv, pt, rdy,
                     input logic e_ifr, e_dv, input logic [31:0] e_pc, input logic e_pv, e_pt,
                     input int e_cnt);
    vec_t v;
    v.fl = fl; v.vin = vin; v.pc = pc; v.pv = pv; v.pt = pt; v.rdy = rdy;
    v.e_ifr = e_ifr; v.e_dv = e_dv; v.e_pc = e_pc; v.e_pv = e_pv; v.e_pt = e_pt;
    v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, vin, input logic [31:0] pc, input logic pv, pt, rdy);
    flush_v_q_i     = fl;
    if_valid_i      = vin;
    if_pc_i         = vin ? pc : 32'h0;
    if_instr_i      = vin ? (pc ^ IMASK) : 32'h0;
    if_pred_v_i     = vin ? pv : 1'b0;
    if_pred_taken_i = vin ? pt : 1'b0;
    dec_ready_i     = rdy;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " if_ready"}, 64'(if_ready_o), 64'(1));
    chk({tag, " dec_valid"}, 64'(dec_valid_o), 64'(0));
    chk({tag, " count"}, 64'(count_o), 64'(0));
    chk({tag, " dec_pc"}, 64'(dec_pc_o), 64'(0));
    chk({tag, " empty"}, 64'(empty_o), 64'(1));
    chk({tag, " full"}, 64'(full_o), 64'(0));
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // Reset held three cycles, then released
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 chk_idle("in_reset");
    reset = 1'b0;
    @(negedge clk);
    #1 chk_idle("after_reset");

    // Fill and drain, including a refused push while full with a pop
    add(0, 1, 32'h100, 0, 0, 0, 1, P, P ? 32'h100 : 32'h0, 0, 0, 0);
    add(0, 1, 32'h104, 0, 0, 0, 1, 1, 32'h100, 0, 0, 1);
    add(0, 1, 32'h108, 0, 0, 0, 1, 1, 32'h100, 0, 0, 2);
    add(0, 1, 32'h10C, 0, 0, 0, 1, 1, 32'h100, 0, 0, 3);
    add(0, 0, 32'h0,   0, 0, 0, 0, 1, 32'h100, 0, 0, 4);
    add(0, 1, 32'h1F0, 0, 0, 1, 0, 1, 32'h100, 0, 0, 4);
    add(0, 0, 32'h0,   0, 0, 1, 1, 1, 32'h104, 0, 0, 3);
    add(0, 0, 32'h0,   0, 0, 1, 1, 1, 32'h108, 0, 0, 2);
    add(0, 0, 32'h0,   0, 0, 1, 1, 1, 32'h10C, 0, 0, 1);
    add(0, 0, 32'h0,   0, 0, 0, 1, 0, 32'h0,   0, 0, 0);

    // Streaming ten bundles with decode always ready (pointer wrap)
    for (int i = 0; i < 10; i++) begin
      logic [31:0] pc_now, pc_prev;
      pc_now  = 32'h200 + 32'(4 * i);
      pc_prev = 32'h200 + 32'(4 * (i - 1));
      add(0, 1, pc_now, 0, 0, 1, 1, P ? 1'b1 : (i > 0),
          P ? pc_now : ((i > 0) ? pc_prev : 32'h0), 0, 0, P ? 0 : ((i > 0) ? 1 : 0));
    end
    add(0, 0, 32'h0, 0, 0, 1, 1, !P, P ? 32'h0 : 32'h224, 0, 0, P ? 0 : 1);
    add(0, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0);

    // Flush with three entries queued and a push/pop offered in the flush cycle
    add(0, 1, 32'h280, 0, 0, 0, 1, P, P ? 32'h280 : 32'h0, 0, 0, 0);
    add(0, 1, 32'h284, 0, 0, 0, 1, 1, 32'h280, 0, 0, 1);
    add(0, 1, 32'h288, 0, 0, 0, 1, 1, 32'h280, 0, 0, 2);
    add(1, 1, 32'h300, 0, 0, 1, 1, 1, 32'h280, 0, 0, 3);
    add(0, 0, 32'h0,   0, 0, 0, 1, 0, 32'h0,   0, 0, 0);
    add(0, 1, 32'h400, 0, 0, 0, 1, P, P ? 32'h400 : 32'h0, 0, 0, 0);
    add(0, 0, 32'h0,   0, 0, 0, 1, 1, 32'h400, 0, 0, 1);
    add(0, 0, 32'h0,   0, 0, 1, 1, 1, 32'h400, 0, 0, 1);
    add(0, 0, 32'h0,   0, 0, 0, 1, 0, 32'h0,   0, 0, 0);

    // Predictor fields carried with the bundle
    add(0, 1, 32'h500, 1, 1, 0, 1, P, P ? 32'h500 : 32'h0, P, P, 0);
    add(0, 1, 32'h504, 0, 0, 0, 1, 1, 32'h500, 1, 1, 1);
    add(0, 0, 32'h0,   0, 0, 1, 1, 1, 32'h500, 1, 1, 2);
    add(0, 0, 32'h0,   0, 0, 1, 1, 1, 32'h504, 0, 0, 1);
    add(0, 0, 32'h0,   0, 0, 0, 1, 0, 32'h0,   0, 0, 0);

    // Empty queue with decode ready: bypass or one-cycle latency
    add(0, 1, 32'h600, 0, 0, 1, 1, P, P ? 32'h600 : 32'h0, 0, 0, 0);
    add(0, 0, 32'h0,   0, 0, 1, 1, !P, P ? 32'h0 : 32'h600, 0, 0, P ? 0 : 1);
    add(0, 0, 32'h0,   0, 0, 0, 1, 0, 32'h0,   0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      string t;
      @(negedge clk);
      drive(vecs[i].fl, vecs[i].vin, vecs[i].pc, vecs[i].pv, vecs[i].pt, vecs[i].rdy);
      #1;
      t = $sformatf("v%0d", i);
      chk({t, " if_ready"}, 64'(if_ready_o), 64'(vecs[i].e_ifr));
      chk({t, " dec_valid"}, 64'(dec_valid_o), 64'(vecs[i].e_dv));
      chk({t, " dec_pc"}, 64'(dec_pc_o), 64'(vecs[i].e_pc));
      chk({t, " dec_instr"}, 64'(dec_instr_o),
          64'(vecs[i].e_dv ? (vecs[i].e_pc ^ IMASK) : 32'h0));
      chk({t, " pred_v"}, 64'(dec_pred_v_o), 64'(vecs[i].e_pv));
      chk({t, " pred_taken"}, 64'(dec_pred_taken_o), 64'(vecs[i].e_pt));
      chk({t, " count"}, 64'(count_o), 64'(vecs[i].e_cnt));
      chk({t, " empty"}, 64'(empty_o), 64'(vecs[i].e_cnt == 0));
      chk({t, " full"}, 64'(full_o), 64'(vecs[i].e_cnt == 4));
    end

    // Asynchronous reset in the middle of operation
    @(negedge clk);
    drive(0, 1, 32'h700, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 32'h704, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("midreset before count", 64'(count_o), 64'(2));
    chk("midreset before dec_pc", 64'(dec_pc_o), 64'(32'h700));
    #1 reset = 1'b1;
    #1 chk_idle("midreset async");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1 chk_idle("midreset released");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
